// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the priority interrupt controller.
package irq_ctrl_pkg;

  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_EDGE = 2'd1;
  localparam logic [1:0] REG_PEND = 2'd2;
  localparam logic [1:0] REG_ISR  = 2'd3;

  // CPU adds this to the vector index to locate the ISR table entry.
  localparam logic [15:0] VEC_BASE = 16'h07F0;

  localparam int IDX_W = 4;

  typedef enum logic [1:0] {IDLE, REQ, ACK} irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Find-lowest-set encoder: index of the lowest set bit of req, valid when any bit is set.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller with in-service nesting, driving a single INT/intack pair.
// Request reaches int_out two cycles after the source; vector is returned combinationally with intack.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQ        = 8,
  parameter int SPURIOUS_VEC = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic [1:0]       reg_addr,
  input  logic [15:0]      reg_wdata,
  input  logic             reg_we,
  output logic [15:0]      reg_rdata,
  output logic             int_out,
  input  logic             intack,
  output logic [15:0]      vec_out
);

  logic [N_IRQ-1:0] mask_q, edge_q, latch_q, isr_q, irq_q;
  logic [N_IRQ-1:0] pend, w1c, eoi_clr, ack_mask, rise;
  logic [IDX_W-1:0] sel_q, sel_d, cand_idx, isr_idx;
  logic             cand_vld, isr_vld, cand_ok, ack;
  logic             wr_mask, wr_edge, wr_pend, wr_isr;
  irq_state_t       state_q, state_d;
  logic             unused_wdata;

  assign unused_wdata = ^reg_wdata[15:N_IRQ];

  // Level sources use the registered sample so both kinds share the same latency.
  assign pend = (edge_q & latch_q) | (~edge_q & irq_q);

  irq_prio_enc #(.N(N_IRQ)) u_cand (
    .req (pend & ~mask_q),
    .idx (cand_idx),
    .vld (cand_vld)
  );

  irq_prio_enc #(.N(N_IRQ)) u_isr (
    .req (isr_q),
    .idx (isr_idx),
    .vld (isr_vld)
  );

  assign cand_ok = cand_vld && (!isr_vld || (cand_idx < isr_idx));

  assign wr_mask = reg_we && (reg_addr == REG_MASK);
  assign wr_edge = reg_we && (reg_addr == REG_EDGE);
  assign wr_pend = reg_we && (reg_addr == REG_PEND);
  assign wr_isr  = reg_we && (reg_addr == REG_ISR);

  assign w1c      = wr_pend ? reg_wdata[N_IRQ-1:0] : '0;
  assign eoi_clr  = (wr_isr && isr_vld) ? (N_IRQ'(1) << isr_idx) : '0;
  assign ack_mask = ack ? (N_IRQ'(1) << sel_q) : '0;
  assign rise     = edge_q & irq & ~irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q  <= '1;
      edge_q  <= '0;
      latch_q <= '0;
      isr_q   <= '0;
      irq_q   <= '0;
      sel_q   <= '0;
      state_q <= IDLE;
    end else begin
      if (wr_mask) mask_q <= reg_wdata[N_IRQ-1:0];
      if (wr_edge) edge_q <= reg_wdata[N_IRQ-1:0];
      // A fresh edge beats both the W1C and the ack clear.
      latch_q <= (latch_q & ~w1c & ~ack_mask) | rise;
      isr_q   <= (isr_q & ~eoi_clr) | ack_mask;
      irq_q   <= irq;
      sel_q   <= sel_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ack     = 1'b0;
    int_out = 1'b0;
    vec_out = '0;
    case (state_q)
      IDLE: begin
        if (intack) vec_out = 16'(SPURIOUS_VEC);
        if (cand_ok) begin
          sel_d   = cand_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        int_out = 1'b1;
        if (intack) begin
          ack     = 1'b1;
          vec_out = {{(16-IDX_W){1'b0}}, sel_q};
          state_d = ACK;
        end else if (cand_ok) begin
          sel_d = cand_idx;
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        if (intack) vec_out = 16'(SPURIOUS_VEC);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      REG_MASK: reg_rdata[N_IRQ-1:0] = mask_q;
      REG_EDGE: reg_rdata[N_IRQ-1:0] = edge_q;
      REG_PEND: reg_rdata[N_IRQ-1:0] = pend;
      REG_ISR:  reg_rdata[N_IRQ-1:0] = isr_q;
      default:  reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations plus randomized traffic against a per-cycle reference model.
`timescale 1ns/1ps
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int N    = 8;
  localparam int SPUR = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] irq = '0;
  logic [1:0]   reg_addr = '0;
  logic [15:0]  reg_wdata = '0;
  logic         reg_we = 1'b0;
  logic         intack = 1'b0;
  logic [15:0]  reg_rdata, vec_out;
  logic         int_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.N_IRQ(N), .SPURIOUS_VEC(SPUR)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_rdata (reg_rdata),
    .int_out   (int_out),
    .intack    (intack),
    .vec_out   (vec_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-source bit arrays, request phase as an integer.
  bit m_mask[N], m_edge[N], m_latch[N], m_isr[N], m_prev[N];
  int m_mode;  // 0 idle, 1 requesting, 2 acknowledged gap
  int m_sel;
  bit m_init = 1'b0;

  always @(negedge clk) begin : model
    bit          pend[N];
    bit          clr[N];
    bit          nl, ack, wv;
    int          win, top;
    logic [31:0] e_rd, e_vec, e_int;

    win = -1;
    top = -1;
    for (int i = 0; i < N; i++) pend[i] = m_edge[i] ? m_latch[i] : m_prev[i];
    for (int i = N - 1; i >= 0; i--) if (pend[i] && !m_mask[i]) win = i;
    for (int i = N - 1; i >= 0; i--) if (m_isr[i]) top = i;
    wv = (win >= 0) && (top < 0 || top > win);

    e_int = (m_mode == 1) ? 1 : 0;
    e_vec = !intack ? 0 : (m_mode == 1) ? m_sel : SPUR;
    e_rd  = 0;
    for (int i = 0; i < N; i++) begin
      case (reg_addr)
        2'd0: e_rd[i] = m_mask[i];
        2'd1: e_rd[i] = m_edge[i];
        2'd2: e_rd[i] = pend[i];
        default: e_rd[i] = m_isr[i];
      endcase
    end

    if (m_init) begin
      chk("int_out", int_out, e_int);
      chk("vec_out", vec_out, e_vec);
      chk("reg_rdata", reg_rdata, e_rd);
    end

    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_mask[i] = 1; m_edge[i] = 0; m_latch[i] = 0; m_isr[i] = 0; m_prev[i] = 0;
      end
      m_mode = 0;
      m_sel  = 0;
      m_init = 1'b1;
    end else if (m_init) begin
      ack = (m_mode == 1) && intack;
      for (int i = 0; i < N; i++) clr[i] = reg_we && reg_addr == 2'd2 && reg_wdata[i];
      if (reg_we && reg_addr == 2'd3 && top >= 0) m_isr[top] = 0;
      for (int i = 0; i < N; i++) begin
        nl = m_latch[i] && !clr[i] && !(ack && i == m_sel);
        if (m_edge[i] && !m_prev[i] && irq[i]) nl = 1;
        m_latch[i] = nl;
      end
      if (ack) m_isr[m_sel] = 1;
      for (int i = 0; i < N; i++) begin
        if (reg_we && reg_addr == 2'd0) m_mask[i] = reg_wdata[i];
        if (reg_we && reg_addr == 2'd1) m_edge[i] = reg_wdata[i];
      end
      case (m_mode)
        0: if (wv) begin m_sel = win; m_mode = 1; end
        1: if (intack) m_mode = 2;
           else if (wv) m_sel = win;
           else m_mode = 0;
        default: m_mode = 0;
      endcase
      for (int i = 0; i < N; i++) m_prev[i] = irq[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    reg_addr  = a;
    reg_wdata = d;
    reg_we    = 1'b1;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input string nm, input logic [15:0] exp);
    reg_addr = a;
    #1;
    chk(nm, reg_rdata, exp);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_int", int_out, 0);
    rd(REG_MASK, "rst_mask", 16'h00FF);
    rd(REG_ISR, "rst_isr", 16'h0000);

    // Level source 0 through request, ack, nesting block and EOI.
    wr(REG_MASK, 16'hFFFE);
    wr(REG_EDGE, 16'h0000);
    irq = 8'h01;
    tick(); chk("t1_int_early", int_out, 0);
    tick(); chk("t1_int", int_out, 1);
    intack = 1'b1; #1; chk("t1_vec", vec_out, 16'h0000);
    tick(); intack = 1'b0;
    chk("t1_ack_gap", int_out, 0);
    rd(REG_ISR, "t1_isr", 16'h0001);
    tick(); chk("t1_held", int_out, 0);
    tick(); chk("t1_held2", int_out, 0);
    wr(REG_ISR, 16'h0000);
    rd(REG_ISR, "t1_eoi", 16'h0000);
    tick(); chk("t1_reassert", int_out, 1);
    irq = '0;
    wr(REG_MASK, 16'hFFFF);
    tick(); tick();

    // Two simultaneous edges served in priority order.
    wr(REG_EDGE, 16'h00FF);
    wr(REG_MASK, 16'h0000);
    irq = 8'h24; tick(); irq = '0;
    rd(REG_PEND, "t2_pend", 16'h0024);
    tick(); chk("t2_int", int_out, 1);
    intack = 1'b1; #1; chk("t2_vec2", vec_out, 16'h0002);
    tick(); intack = 1'b0;
    wr(REG_ISR, 16'h0000);
    tick(); chk("t2_int5", int_out, 1);
    intack = 1'b1; #1; chk("t2_vec5", vec_out, 16'h0005);
    tick(); intack = 1'b0;
    rd(REG_PEND, "t2_pend_end", 16'h0000);
    wr(REG_ISR, 16'h0000);

    // Nesting: ISR[3] blocks 6 but not 1.
    irq = 8'h08; tick(); irq = '0;
    tick(); chk("t3_req3", int_out, 1);
    intack = 1'b1; tick(); intack = 1'b0;
    rd(REG_ISR, "t3_isr3", 16'h0008);
    irq = 8'h40; tick(); irq = '0;
    tick(); tick(); chk("t3_blocked", int_out, 0);
    irq = 8'h02; tick(); irq = '0;
    tick(); chk("t3_int1", int_out, 1);
    intack = 1'b1; #1; chk("t3_vec1", vec_out, 16'h0001);
    tick(); intack = 1'b0;
    rd(REG_ISR, "t3_isr_a", 16'h000A);
    wr(REG_ISR, 16'h0000);
    rd(REG_ISR, "t3_eoi1", 16'h0008);
    wr(REG_PEND, 16'h0040);
    wr(REG_ISR, 16'h0000);
    rd(REG_ISR, "t3_eoi2", 16'h0000);

    // Level withdrawn before the CPU acknowledges: spurious vector.
    wr(REG_EDGE, 16'h0000);
    irq = 8'h10; tick();
    tick(); chk("t4_req", int_out, 1);
    irq = '0; tick();
    tick(); chk("t4_drop", int_out, 0);
    intack = 1'b1; #1; chk("t4_spur", vec_out, 16'h000F);
    tick(); intack = 1'b0;
    rd(REG_ISR, "t4_isr", 16'h0000);

    // Edge set beats a same-cycle W1C.
    wr(REG_MASK, 16'h00FF);
    wr(REG_EDGE, 16'h00FF);
    irq = 8'h08; tick(); irq = '0;
    rd(REG_PEND, "t5_latch", 16'h0008);
    tick();
    irq = 8'h08;
    reg_addr = REG_PEND; reg_wdata = 16'h0008; reg_we = 1'b1;
    tick(); reg_we = 1'b0;
    rd(REG_PEND, "t5_race", 16'h0008);
    wr(REG_PEND, 16'h0008);
    rd(REG_PEND, "t5_w1c", 16'h0000);
    irq = '0;

    // Reset while requesting.
    wr(REG_EDGE, 16'h0000);
    wr(REG_MASK, 16'h0000);
    irq = 8'h01; tick();
    tick(); chk("t5_req", int_out, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_rst_int", int_out, 0);
    rd(REG_MASK, "t5_rst_mask", 16'h00FF);
    rd(REG_ISR, "t5_rst_isr", 16'h0000);
    irq = '0;

    // Randomized traffic, checked cycle by cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom % 4 == 0) irq = irq ^ N'(1 << ($urandom % N));
      reg_we    = ($urandom % 5 == 0);
      reg_addr  = ($urandom % 3 == 0) ? REG_ISR : 2'($urandom % 4);
      reg_wdata = 16'($urandom);
      intack    = !intack && ($urandom % 3 == 0) && (int_out || ($urandom % 6 == 0));
      rst       = ($urandom % 600 == 0);
      tick();
    end
    reg_we = 1'b0;
    intack = 1'b0;
    rst    = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
